// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: FSM state encoding and mode constants.
package mem_copy_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_addr_gen.sv
// Address generator: latched source/destination bases, word index and end-of-block compare.
module mem_addr_gen #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            if (load_i) begin
                src_q <= src_i;
                dst_q <= dst_i;
                len_q <= len_i;
            end
            idx_q <= idx_d;
        end
    end

    // Sums truncate to ADDR_W so blocks wrap past the top of the address space.
    assign rd_addr_o = src_q + ADDR_W'(idx_q);
    assign wr_addr_o = dst_q + ADDR_W'(idx_q);
    assign last_o    = (idx_q == len_q - LEN_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Small DMA initiator on the CPU data-memory port: copies a block of words or fills it with a constant.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Length,
    input  logic [DATA_W-1:0] FillData,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic [LEN_W-1:0]  WordsDone,
    output logic [ADDR_W-1:0] Adresa,
    output logic [DATA_W-1:0] WD,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    state_e            state_q;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buf_q;
    logic [LEN_W-1:0]  words_q;

    logic              load;
    logic              advance;
    logic              last;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign load    = (state_q == ST_IDLE) && Start;
    assign advance = (state_q == ST_WR);

    mem_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk_i     (Clock),
        .rst_n_i   (Resetn),
        .load_i    (load),
        .advance_i (advance),
        .src_i     (SrcAddr),
        .dst_i     (DstAddr),
        .len_i     (Length),
        .rd_addr_o (rd_addr),
        .wr_addr_o (wr_addr),
        .last_o    (last)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            buf_q   <= '0;
            words_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        mode_q  <= Mode;
                        fill_q  <= FillData;
                        words_q <= '0;
                        if (Length == '0) begin
                            state_q <= ST_DONE;
                        end else if (Mode == MODE_FILL) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    buf_q   <= ReadData;
                    state_q <= Abort ? ST_IDLE : ST_WR;
                end
                ST_WR: begin
                    // The write decoded this cycle commits even when aborted, so it is counted.
                    words_q <= words_q + LEN_W'(1);
                    if (Abort) begin
                        state_q <= ST_IDLE;
                    end else if (last) begin
                        state_q <= ST_DONE;
                    end else if (mode_q == MODE_FILL) begin
                        state_q <= ST_WR;
                    end else begin
                        state_q <= ST_RD;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are also gated by Resetn so a reset edge can never commit a write.
    always_comb begin
        Busy     = (state_q == ST_RD) || (state_q == ST_WR);
        Done     = (state_q == ST_DONE);
        MemRead  = (state_q == ST_RD) && Resetn;
        MemWrite = (state_q == ST_WR) && Resetn;
        Adresa   = '0;
        WD       = '0;
        if (state_q == ST_RD) begin
            Adresa = rd_addr;
        end else if (state_q == ST_WR) begin
            Adresa = wr_addr;
            WD     = (mode_q == MODE_FILL) ? fill_q : buf_q;
        end
    end

    assign WordsDone = words_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural DataMemory responder.
module tb_mem_copy_engine;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic        Mode;
    logic [15:0] SrcAddr;
    logic [15:0] DstAddr;
    logic [15:0] Length;
    logic [15:0] FillData;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic [15:0] WordsDone;
    logic [15:0] Adresa;
    logic [15:0] WD;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] ReadData;

    logic [15:0] mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [15:0] tb_data;

    int          total;
    int          bad;
    int          nb;
    int          nd;
    int          nr;
    int          nw;
    logic        fin;
    logic [15:0] rq[$];
    logic [15:0] wq[$];

    mem_copy_engine #(
        .ADDR_W (16),
        .DATA_W (16),
        .LEN_W  (16)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .Mode      (Mode),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .Length    (Length),
        .FillData  (FillData),
        .Abort     (Abort),
        .Busy      (Busy),
        .Done      (Done),
        .WordsDone (WordsDone),
        .Adresa    (Adresa),
        .WD        (WD),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign ReadData = mem[Adresa];

    always @(posedge Clock) begin
        if (MemWrite) begin
            mem[Adresa] <= WD;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tick();
        tb_we   = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input logic [15:0] f);
        Mode     = m;
        SrcAddr  = s;
        DstAddr  = d;
        Length   = n;
        FillData = f;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
    endtask

    // Samples each cycle after the accepting edge until Busy drops (bounded by maxc).
    task automatic run(input int maxc, input int abort_wr, input int restart_at);
        nb = 0; nd = 0; nr = 0; nw = 0; fin = 1'b0;
        rq.delete();
        wq.delete();
        for (int c = 0; c < maxc; c++) begin
            if (Busy) nb++;
            if (Done) nd++;
            if (MemRead) begin nr++; rq.push_back(Adresa); end
            if (MemWrite) begin nw++; wq.push_back(Adresa); end
            if (!Busy) begin
                fin = 1'b1;
                break;
            end
            Abort = (abort_wr > 0) && MemWrite && (nw == abort_wr);
            if (c == restart_at) begin
                Start   = 1'b1;
                Mode    = 1'b1;
                DstAddr = 16'd300;
                Length  = 16'd2;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Abort = 1'b0;
        Start = 1'b0;
        chk("finished", 32'(fin), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0;
        Resetn = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillData = '0; Abort = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;

        repeat (2) tick();
        chk("reset_ctrl", {Busy, Done, MemWrite, MemRead}, 32'd0);
        chk("reset_addr", Adresa, 32'd0);
        chk("reset_wd", WD, 32'd0);
        chk("reset_words", WordsDone, 32'd0);
        Resetn = 1'b1;
        tick();

        // Copy 3 words 10 -> 40
        poke(16'd10, 16'h1234); poke(16'd11, 16'hABCD); poke(16'd12, 16'h0F0F);
        launch(1'b0, 16'd10, 16'd40, 16'd3, 16'h0000);
        run(20, 0, -1);
        chk("copy_busy", nb, 32'd6);
        chk("copy_done", nd, 32'd1);
        chk("copy_words", WordsDone, 32'd3);
        chk("copy_nread", nr, 32'd3);
        tick();
        chk("copy_idle", {Busy, Done}, 32'd0);
        chk("copy_m40", mem[40], 32'h1234);
        chk("copy_m41", mem[41], 32'hABCD);
        chk("copy_m42", mem[42], 32'h0F0F);

        // Fill 4 words at 100
        launch(1'b1, 16'd0, 16'd100, 16'd4, 16'hBEEF);
        run(20, 0, -1);
        chk("fill_busy", nb, 32'd4);
        chk("fill_done", nd, 32'd1);
        chk("fill_nread", nr, 32'd0);
        chk("fill_words", WordsDone, 32'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_m%0d", 100 + i), mem[100 + i], 32'hBEEF);
        end

        // Zero length
        launch(1'b0, 16'd10, 16'd500, 16'd0, 16'h0000);
        run(5, 0, -1);
        chk("zero_done", nd, 32'd1);
        chk("zero_busy", nb, 32'd0);
        chk("zero_strobes", nr + nw, 32'd0);
        chk("zero_words", WordsDone, 32'd0);
        tick();
        chk("zero_idle", {Busy, Done}, 32'd0);

        // Wrap with overlapping regions: forward copy propagates mem[FFFE]
        poke(16'hFFFE, 16'h1111); poke(16'hFFFF, 16'h2222);
        poke(16'h0000, 16'h3333); poke(16'h0001, 16'h4444);
        launch(1'b0, 16'hFFFE, 16'hFFFF, 16'd3, 16'h0000);
        run(20, 0, -1);
        chk("wrap_nrd", rq.size(), 32'd3);
        chk("wrap_nwr", wq.size(), 32'd3);
        chk("wrap_rd0", rq[0], 32'hFFFE);
        chk("wrap_rd1", rq[1], 32'hFFFF);
        chk("wrap_rd2", rq[2], 32'h0000);
        chk("wrap_wr0", wq[0], 32'hFFFF);
        chk("wrap_wr1", wq[1], 32'h0000);
        chk("wrap_wr2", wq[2], 32'h0001);
        tick();
        chk("wrap_m0001", mem[16'h0001], 32'h1111);

        // Abort on third WR cycle, with an ignored Start while busy
        for (int i = 60; i < 68; i++) poke(16'(i), 16'h0000);
        poke(16'd300, 16'h5555);
        launch(1'b0, 16'd10, 16'd60, 16'd8, 16'h0000);
        run(30, 3, 1);
        chk("abort_nwr", nw, 32'd3);
        chk("abort_done", nd, 32'd0);
        chk("abort_words", WordsDone, 32'd3);
        chk("abort_nbusy", nb, 32'd6);
        chk("abort_wr2", wq[2], 32'd62);
        tick();
        chk("abort_idle", {Busy, Done, MemWrite, MemRead}, 32'd0);
        chk("abort_m62", mem[62], 32'h0F0F);
        chk("abort_m63", mem[63], 32'h0000);
        chk("ignored_start", mem[300], 32'h5555);

        // Reset during the second WR cycle of a fill
        for (int i = 200; i < 204; i++) poke(16'(i), 16'h0000);
        launch(1'b1, 16'd0, 16'd200, 16'd4, 16'hCAFE);
        tick();
        chk("rst_pre_wr", {MemWrite, Adresa}, {15'd0, 1'b1, 16'd201});
        Resetn = 1'b0;
        #1;
        chk("rst_gate", MemWrite, 32'd0);
        tick();
        chk("rst_ctrl", {Busy, Done, MemWrite, MemRead}, 32'd0);
        chk("rst_bus", {Adresa, WD}, 32'd0);
        chk("rst_words", WordsDone, 32'd0);
        chk("rst_m200", mem[200], 32'hCAFE);
        chk("rst_m201", mem[201], 32'h0000);
        Resetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
